// File: rtl/dff_delay_line.sv
// dff_delay_line: multi-stage enabled delay line with flush, valid tracking, tap select and fill count
module dff_delay_line #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int TAP_W        = $clog2(DEPTH + 1),
    parameter int ZERO_INVALID = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sclr,
    input  logic [TAP_W-1:0] tap,
    input  logic [WIDTH-1:0] inp,
    input  logic             in_valid,
    output logic [WIDTH-1:0] outp,
    output logic             out_valid,
    output logic [TAP_W-1:0] fill,
    output logic             full
);
    logic [WIDTH-1:0] r_data [1:DEPTH];
    logic [DEPTH:1]   r_valid;
    logic [TAP_W-1:0] r_fill;
    logic [TAP_W-1:0] w_sel;
    logic [WIDTH-1:0] w_in_data;
    assign w_in_data = (ZERO_INVALID != 0 && !in_valid) ? '0 : inp;
    assign w_sel     = (tap > TAP_W'(DEPTH)) ? TAP_W'(DEPTH) : tap;
    // stage registers: shift on enable, flush clears everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i <= DEPTH; i++) r_data[i] <= '0;
            r_valid <= '0;
        end else if (en) begin
            if (sclr) begin
                for (int i = 1; i <= DEPTH; i++) r_data[i] <= '0;
                r_valid <= '0;
            end else begin
                r_data[1]  <= w_in_data;
                r_valid[1] <= in_valid;
                for (int i = 2; i <= DEPTH; i++) begin
                    r_data[i]  <= r_data[i-1];
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end
    end
    // occupancy: one in at the head, one out at the tail
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fill <= '0;
        else if (en) r_fill <= sclr ? '0 : r_fill + TAP_W'(in_valid) - TAP_W'(r_valid[DEPTH]);
    end
    assign outp      = (w_sel == '0) ? inp : r_data[w_sel];
    assign out_valid = (w_sel == '0) ? in_valid : r_valid[w_sel];
    assign fill      = r_fill;
    assign full      = (r_fill == TAP_W'(DEPTH));
endmodule
